// File: rtl/snn_phase_scheduler_if.sv
// rtl/snn_phase_scheduler_if.sv - control/status bundle between the phase scheduler and its environment
// master: the scheduler; slave: controller, conv/pool engines and arbiter as seen from outside.
interface snn_phase_scheduler_if #(
  parameter int TIMESTEP_BITS = 16
);
  logic                     start;
  logic                     abort;
  logic                     skip_pool;
  logic                     conv_start;
  logic                     conv_done;
  logic                     pool_start;
  logic                     pool_done;
  logic                     arb_active;
  logic                     arb_enable;
  logic                     conv_or_pool;
  logic                     busy;
  logic                     done;
  logic                     error;
  logic [TIMESTEP_BITS-1:0] timestep_count;

  modport master (
    input  start, abort, skip_pool, conv_done, pool_done, arb_active,
    output conv_start, pool_start, arb_enable, conv_or_pool, busy, done, error,
           timestep_count
  );

  modport slave (
    output start, abort, skip_pool, conv_done, pool_done, arb_active,
    input  conv_start, pool_start, arb_enable, conv_or_pool, busy, done, error,
           timestep_count
  );
endinterface

// File: rtl/snn_phase_scheduler.sv
// rtl/snn_phase_scheduler.sv - conv/pool timestep sequencer driving the feature-map BRAM arbiter
// Moore FSM; every output is registered from the next state so it is glitch-free at the arbiter.
module snn_phase_scheduler #(
  parameter int TIMESTEP_BITS  = 16,
  parameter int DRAIN_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                  clk,
  input  logic                  rst,
  snn_phase_scheduler_if.master sched_io
);

  localparam int DRAIN_MAX = (DRAIN_CYCLES < 1) ? 1 : DRAIN_CYCLES;
  localparam int DRAIN_W   = $clog2(DRAIN_MAX + 1);
  localparam bit WD_EN     = (TIMEOUT_CYCLES != 0);
  localparam int WD_LAST   = WD_EN ? TIMEOUT_CYCLES - 1 : 0;
  localparam int WD_W      = (WD_LAST < 1) ? 1 : $clog2(WD_LAST + 1);

  typedef enum logic [3:0] {
    IDLE,
    C_START,
    C_RUN,
    C_DRAIN,
    SWITCH,
    P_START,
    P_RUN,
    P_DRAIN,
    FINISH
  } state_t;

  state_t                   state_q, state_d;
  logic                     skip_q, skip_d;
  logic                     error_q, error_d;
  logic [DRAIN_W-1:0]       drain_q, drain_d;
  logic [WD_W-1:0]          wd_q, wd_d;
  logic [TIMESTEP_BITS-1:0] count_q, count_d;

  logic arb_enable_q;
  logic conv_or_pool_q;
  logic conv_start_q;
  logic pool_start_q;
  logic busy_q;
  logic done_q;

  logic drain_met;
  logic drain_exit;
  logic wd_expired;

  // Drain must both age out and see the arbiter idle, so no grant is in flight at the switch.
  assign drain_met  = (drain_q >= DRAIN_W'(DRAIN_MAX));
  assign drain_exit = drain_met && !sched_io.arb_active;
  assign wd_expired = WD_EN && (wd_q == WD_W'(WD_LAST));

  always_comb begin
    state_d = state_q;
    skip_d  = skip_q;
    error_d = error_q;
    drain_d = drain_q;
    wd_d    = wd_q;
    count_d = count_q;

    if (state_q != IDLE && sched_io.abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (sched_io.start) begin
            state_d = C_START;
            skip_d  = sched_io.skip_pool;
            error_d = 1'b0;
          end
        end
        C_START: begin
          state_d = C_RUN;
          wd_d    = '0;
        end
        C_RUN: begin
          if (sched_io.conv_done) begin
            state_d = C_DRAIN;
            drain_d = DRAIN_W'(1);
          end else if (wd_expired) begin
            state_d = IDLE;
            error_d = 1'b1;
          end else begin
            wd_d = wd_q + WD_W'(1);
          end
        end
        C_DRAIN: begin
          if (drain_exit) begin
            state_d = skip_q ? FINISH : SWITCH;
          end else if (!drain_met) begin
            drain_d = drain_q + DRAIN_W'(1);
          end
        end
        SWITCH: begin
          state_d = P_START;
        end
        P_START: begin
          state_d = P_RUN;
          wd_d    = '0;
        end
        P_RUN: begin
          if (sched_io.pool_done) begin
            state_d = P_DRAIN;
            drain_d = DRAIN_W'(1);
          end else if (wd_expired) begin
            state_d = IDLE;
            error_d = 1'b1;
          end else begin
            wd_d = wd_q + WD_W'(1);
          end
        end
        P_DRAIN: begin
          if (drain_exit) begin
            state_d = FINISH;
          end else if (!drain_met) begin
            drain_d = drain_q + DRAIN_W'(1);
          end
        end
        FINISH: begin
          state_d = IDLE;
          count_d = count_q + TIMESTEP_BITS'(1);
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      skip_q         <= 1'b0;
      error_q        <= 1'b0;
      drain_q        <= '0;
      wd_q           <= '0;
      count_q        <= '0;
      arb_enable_q   <= 1'b0;
      conv_or_pool_q <= 1'b1;
      conv_start_q   <= 1'b0;
      pool_start_q   <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      skip_q         <= skip_d;
      error_q        <= error_d;
      drain_q        <= drain_d;
      wd_q           <= wd_d;
      count_q        <= count_d;
      arb_enable_q   <= state_d inside {C_START, C_RUN, C_DRAIN, P_START, P_RUN, P_DRAIN};
      conv_or_pool_q <= !(state_d inside {SWITCH, P_START, P_RUN, P_DRAIN});
      conv_start_q   <= (state_d == C_START);
      pool_start_q   <= (state_d == P_START);
      busy_q         <= (state_d != IDLE);
      done_q         <= (state_d == FINISH);
    end
  end

  assign sched_io.arb_enable     = arb_enable_q;
  assign sched_io.conv_or_pool   = conv_or_pool_q;
  assign sched_io.conv_start     = conv_start_q;
  assign sched_io.pool_start     = pool_start_q;
  assign sched_io.busy           = busy_q;
  assign sched_io.done           = done_q;
  assign sched_io.error          = error_q;
  assign sched_io.timestep_count = count_q;

endmodule

// File: tb/tb_snn_phase_scheduler.sv
// tb/tb_snn_phase_scheduler.sv - directed self-checking bench for snn_phase_scheduler
// Cycle 0 of each timestep is the cycle in which start is driven high.
module tb_snn_phase_scheduler;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  snn_phase_scheduler_if #(.TIMESTEP_BITS(2)) tsi ();

  snn_phase_scheduler #(
    .TIMESTEP_BITS (2),
    .DRAIN_CYCLES  (2),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .sched_io(tsi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_cnt(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one timestep's stimulus and records the cycle of each observed event (-1 = never).
  task automatic run_ts(input bit skip, input int conv_at, input int pool_at,
                        input int arb_from, input int arb_len, input int start2_at,
                        input int ncyc,
                        output int cs_at, output int ps_at, output int done_at,
                        output int busy_low_at, output int cop_fall_at,
                        output int err_at, output int viol);
    logic prev_cop;
    cs_at = -1; ps_at = -1; done_at = -1; busy_low_at = -1;
    cop_fall_at = -1; err_at = -1; viol = 0;
    prev_cop = tsi.conv_or_pool;
    for (int c = 0; c <= ncyc; c++) begin
      if (tsi.conv_start === 1'b1 && cs_at < 0) cs_at = c;
      if (tsi.pool_start === 1'b1 && ps_at < 0) ps_at = c;
      if (tsi.done === 1'b1 && done_at < 0) done_at = c;
      if (c > 0 && tsi.busy === 1'b0 && busy_low_at < 0) busy_low_at = c;
      if (c > 0 && prev_cop === 1'b1 && tsi.conv_or_pool === 1'b0 && cop_fall_at < 0)
        cop_fall_at = c;
      if (tsi.error === 1'b1 && err_at < 0) err_at = c;
      if (tsi.conv_or_pool !== prev_cop && tsi.arb_enable !== 1'b0) viol++;
      prev_cop = tsi.conv_or_pool;
      tsi.start      = (c == 0) || (c == start2_at);
      tsi.skip_pool  = (c == 0) ? skip : ~skip;
      tsi.conv_done  = (c == conv_at);
      tsi.pool_done  = (c == pool_at);
      tsi.arb_active = (c >= arb_from) && (c < arb_from + arb_len);
      tick();
    end
    tsi.start      = 1'b0;
    tsi.skip_pool  = 1'b0;
    tsi.conv_done  = 1'b0;
    tsi.pool_done  = 1'b0;
    tsi.arb_active = 1'b0;
  endtask

  initial begin
    int cs, ps, dn, bl, cf, er, vi;
    checks         = 0;
    failures       = 0;
    rst            = 1'b1;
    tsi.start      = 1'b0;
    tsi.abort      = 1'b0;
    tsi.skip_pool  = 1'b0;
    tsi.conv_done  = 1'b0;
    tsi.pool_done  = 1'b0;
    tsi.arb_active = 1'b0;
    tick();
    tick();

    check_bit("rst_busy", tsi.busy, 1'b0);
    check_bit("rst_arb_enable", tsi.arb_enable, 1'b0);
    check_bit("rst_conv_or_pool", tsi.conv_or_pool, 1'b1);
    check_bit("rst_conv_start", tsi.conv_start, 1'b0);
    check_bit("rst_pool_start", tsi.pool_start, 1'b0);
    check_bit("rst_done", tsi.done, 1'b0);
    check_bit("rst_error", tsi.error, 1'b0);
    check_cnt("rst_count", tsi.timestep_count, 2'd0);
    rst = 1'b0;
    tick();

    // Minimum timestep with pooling.
    run_ts(1'b0, 2, 7, 0, 0, -1, 12, cs, ps, dn, bl, cf, er, vi);
    check_int("t1_conv_start_cycle", cs, 1);
    check_int("t1_pool_start_cycle", ps, 6);
    check_int("t1_done_cycle", dn, 10);
    check_int("t1_busy_low_cycle", bl, 11);
    check_int("t1_switch_cycle", cf, 5);
    check_int("t1_phase_violations", vi, 0);
    check_cnt("t1_count", tsi.timestep_count, 2'd1);

    // Skip pooling; the next timestep is started in the first IDLE cycle (cycle 6).
    run_ts(1'b1, 2, -1, 0, 0, -1, 5, cs, ps, dn, bl, cf, er, vi);
    check_int("t2_conv_start_cycle", cs, 1);
    check_int("t2_no_pool_start", ps, -1);
    check_int("t2_done_cycle", dn, 5);
    check_int("t2_no_phase_switch", cf, -1);
    check_cnt("t2_count", tsi.timestep_count, 2'd2);

    // Back-to-back start, arbiter busy for 5 cycles from conv_done: C_DRAIN spans cycles 3..7.
    run_ts(1'b0, 2, 10, 2, 5, -1, 14, cs, ps, dn, bl, cf, er, vi);
    check_int("t3_b2b_conv_start_cycle", cs, 1);
    check_int("t3_switch_cycle", cf, 8);
    check_int("t3_pool_start_cycle", ps, 9);
    check_int("t3_done_cycle", dn, 13);
    check_int("t3_busy_low_cycle", bl, 14);
    check_int("t3_phase_violations", vi, 0);
    check_cnt("t3_count", tsi.timestep_count, 2'd3);

    // No pool_done: P_RUN occupies cycles 7..14, error and IDLE in cycle 15.
    run_ts(1'b0, 2, -1, 0, 0, -1, 16, cs, ps, dn, bl, cf, er, vi);
    check_int("t4_err_cycle", er, 15);
    check_int("t4_busy_low_cycle", bl, 15);
    check_int("t4_no_done", dn, -1);
    check_bit("t4_error_sticky", tsi.error, 1'b1);
    check_cnt("t4_count_unchanged", tsi.timestep_count, 2'd3);

    // Next start clears error; count wraps 3 -> 0.
    run_ts(1'b0, 2, 7, 0, 0, -1, 11, cs, ps, dn, bl, cf, er, vi);
    check_int("t5_done_cycle", dn, 10);
    check_bit("t5_error_cleared", tsi.error, 1'b0);
    check_cnt("t5_count_wrap", tsi.timestep_count, 2'd0);

    // pool_done on the timeout cycle wins; a start during busy is ignored.
    run_ts(1'b0, 2, 14, 0, 0, 5, 18, cs, ps, dn, bl, cf, er, vi);
    check_int("t6_done_cycle", dn, 17);
    check_int("t6_busy_low_cycle", bl, 18);
    check_int("t6_no_error", er, -1);
    check_cnt("t6_count", tsi.timestep_count, 2'd1);

    // Abort in C_RUN.
    tsi.start = 1'b1;
    tick();
    tsi.start = 1'b0;
    check_bit("t7_conv_start", tsi.conv_start, 1'b1);
    tick();
    check_bit("t7_run_arb_enable", tsi.arb_enable, 1'b1);
    tsi.abort = 1'b1;
    tick();
    tsi.abort = 1'b0;
    check_bit("t7_abort_busy", tsi.busy, 1'b0);
    check_bit("t7_abort_arb_enable", tsi.arb_enable, 1'b0);
    check_bit("t7_abort_conv_or_pool", tsi.conv_or_pool, 1'b1);
    check_bit("t7_abort_done", tsi.done, 1'b0);
    check_bit("t7_abort_error", tsi.error, 1'b0);
    check_cnt("t7_abort_count", tsi.timestep_count, 2'd1);
    tick();

    // Asynchronous reset in the middle of P_RUN (cycle 7).
    tsi.start = 1'b1;
    tick();
    tsi.start = 1'b0;
    tick();
    tsi.conv_done = 1'b1;
    tick();
    tsi.conv_done = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check_bit("t8_prun_arb_enable", tsi.arb_enable, 1'b1);
    check_bit("t8_prun_conv_or_pool", tsi.conv_or_pool, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check_bit("t8_rst_busy", tsi.busy, 1'b0);
    check_bit("t8_rst_arb_enable", tsi.arb_enable, 1'b0);
    check_bit("t8_rst_conv_or_pool", tsi.conv_or_pool, 1'b1);
    check_bit("t8_rst_pool_start", tsi.pool_start, 1'b0);
    check_bit("t8_rst_done", tsi.done, 1'b0);
    check_cnt("t8_rst_count", tsi.timestep_count, 2'd0);
    tick();
    rst = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
